// File: rtl/mandel_frame_scheduler.sv
// Raster-order frame sequencer: feeds per-pixel coordinates to the Mandelbrot core and writes colours.
// Optional MANDEL_SCHED_ABORT_EN: frame_start during a running frame restarts it with the new viewport.
module mandel_frame_scheduler #(
   parameter int unsigned FB_W   = 320,
   parameter int unsigned FB_H   = 240,
   parameter int unsigned FRAC   = 22,
   parameter int unsigned ADDR_W = 17
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
   input  logic signed [24:0]  x0_q,
   input  logic signed [24:0]  y0_q,
   input  logic signed [24:0]  step_q,
   output logic                core_start,
   output logic signed [24:0]  core_cx,
   output logic signed [24:0]  core_cy,
   input  logic                core_busy,
   input  logic                core_done,
   input  logic [11:0]         core_rgb,
   output logic                fb_we,
   output logic [ADDR_W-1:0]   fb_addr,
   output logic [11:0]         fb_wdata,
   input  logic                fb_ready,
   output logic                frame_busy,
   output logic                frame_done
);

   localparam int unsigned XW = $clog2(FB_W);
   localparam int unsigned YW = $clog2(FB_H);
   localparam logic [XW-1:0] X_LAST = XW'(FB_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(FB_H - 1);

   if (FRAC == 0 || FRAC > 24 || FB_W < 2 || FB_H < 2 ||
       FB_W * FB_H > (1 << ADDR_W)) begin : g_bad_cfg
      $error("mandel_frame_scheduler: unsupported parameter combination");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

   state_e              state_q, state_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic signed [24:0]  cx_q, cx_d;
   logic signed [24:0]  cy_q, cy_d;
   logic signed [24:0]  orig_x_q, orig_x_d;
   logic signed [24:0]  pitch_q, pitch_d;
   logic [11:0]         wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                load;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         x_q      <= '0;
         y_q      <= '0;
         addr_q   <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         orig_x_q <= '0;
         pitch_q  <= '0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         addr_q   <= addr_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         orig_x_q <= orig_x_d;
         pitch_q  <= pitch_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      addr_d     = addr_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      orig_x_d   = orig_x_q;
      pitch_d    = pitch_q;
      wdata_d    = wdata_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      core_start = 1'b0;
      load       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (frame_start) load = 1'b1;
         end
         StIssue: begin
            if (!core_busy) begin
               core_start = 1'b1;
               state_d    = StWait;
            end
         end
         StWait: begin
            if (core_done) begin
               wdata_d = core_rgb;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (fb_ready) begin
               if (x_q == X_LAST && y_q == Y_LAST) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  state_d = StIssue;
                  addr_d  = addr_q + ADDR_W'(1);
                  if (x_q != X_LAST) begin
                     x_d  = x_q + XW'(1);
                     cx_d = cx_q + pitch_q;
                  end else begin
                     // Imaginary axis runs downward: next row is one pitch lower.
                     x_d  = '0;
                     y_d  = y_q + YW'(1);
                     cx_d = orig_x_q;
                     cy_d = cy_q - pitch_q;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

`ifdef MANDEL_SCHED_ABORT_EN
      // Abort wins over everything else in flight; ISSUE then waits for the core to drain.
      if (frame_start && busy_q) begin
         load       = 1'b1;
         core_start = 1'b0;
         done_d     = 1'b0;
      end
`endif

      if (load) begin
         orig_x_d = x0_q;
         pitch_d  = step_q;
         x_d      = '0;
         y_d      = '0;
         addr_d   = '0;
         cx_d     = x0_q;
         cy_d     = y0_q;
         busy_d   = 1'b1;
         state_d  = StIssue;
      end
   end

   assign core_cx    = cx_q;
   assign core_cy    = cy_q;
   assign fb_we      = (state_q == StWrite);
   assign fb_addr    = addr_q;
   assign fb_wdata   = wdata_q;
   assign frame_busy = busy_q;
   assign frame_done = done_q;

endmodule

// File: doc/mandel_frame_scheduler.md
# mandel_frame_scheduler

Frame-level sequencer sitting directly upstream of the Mandelbrot pixel core and downstream of the viewport/button logic. On a frame request it walks every framebuffer pixel in raster order and derives each pixel's complex coordinate (cx, cy) incrementally from a latched viewport origin and pitch. For each pixel it issues one start to the core, captures the returned RGB444 colour, and writes it to the framebuffer through a ready/valid write port.

## Interface
Parameters:
- FB_W, 320, framebuffer width in pixels (≥2)
- FB_H, 240, framebuffer height in pixels (≥2)
- FRAC, 22, fractional bits of all Q-format coordinates
- ADDR_W, 17, framebuffer address width; FB_W*FB_H ≤ 2^ADDR_W

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle frame request
- x0_q  in  25 signed  real part of top-left pixel, Q(FRAC)
- y0_q  in  25 signed  imag part of top-left pixel, Q(FRAC)
- step_q  in  25 signed  pixel pitch, Q(FRAC)
- core_start  out  1  one-cycle pixel start to core
- core_cx  out  25 signed  pixel real coordinate
- core_cy  out  25 signed  pixel imag coordinate
- core_busy  in  1  core busy
- core_done  in  1  core one-cycle completion pulse
- core_rgb  in  12  core colour result, valid with core_done
- fb_we  out  1  framebuffer write valid
- fb_addr  out  ADDR_W  write address, y*FB_W + x
- fb_wdata  out  12  write data, RGB444
- fb_ready  in  1  framebuffer accepts write this cycle
- frame_busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel written

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE.
- IDLE: on frame_start, latch x0_q, y0_q, step_q; set x=0, y=0, addr=0, core_cx=x0_q, core_cy=y0_q; set frame_busy=1; go to ISSUE.
- ISSUE: if core_busy=0, pulse core_start for one cycle and go to WAIT; otherwise stay. core_cx/core_cy stay stable from ISSUE until the next pixel advance.
- WAIT: on core_done, register core_rgb into fb_wdata and go to WRITE. core_done outside WAIT is ignored.
- WRITE: hold fb_we=1 with fb_addr/fb_wdata stable until a cycle where fb_ready=1; in that cycle the write completes.
  - If the pixel is not the last: advance and go to ISSUE.
  - If the pixel is the last (x=FB_W-1, y=FB_H-1): pulse frame_done, clear frame_busy, go to IDLE.
- Advance:
  - If x<FB_W-1: x+=1, core_cx+=step.
  - Else: x=0, y+=1, core_cx=x0, core_cy-=step (imaginary axis decreases downward).
  - addr+=1 in both cases.
- Arithmetic: 25-bit two's complement add/sub, wraps silently, no saturation. No multipliers; addr is maintained incrementally.
- frame_start outside IDLE is ignored (see Configuration).

## Timing
- Reset values:
  - Outputs: core_start=0, core_cx=0, core_cy=0, fb_we=0, fb_addr=0, fb_wdata=0, frame_busy=0, frame_done=0.
  - State: FSM=IDLE.
- frame_start at cycle T → frame_busy=1 and state ISSUE at T+1 → core_start=1 at T+1 if core_busy=0.
- core_done at cycle D → fb_we=1 at D+1. With fb_ready=1 at D+1, the next core_start occurs at D+2.
- Per-pixel overhead beyond core latency: 2 cycles (ISSUE + WRITE) when there is no backpressure.
- frame_done asserts in the cycle after the final accepted write, and coincides with frame_busy falling.
- Reset mid-frame: all state returns to reset values at the next edge. No write is issued after rst is sampled high.

## Configuration
- MANDEL_SCHED_ABORT_EN defined: frame_start while frame_busy=1 aborts the current frame.
  - Any pending write is dropped (fb_we=0 next cycle).
  - The new viewport is latched and the FSM restarts from pixel 0 in ISSUE.
  - A core_done from the abandoned pixel is discarded: the FSM waits for core_busy=0 before issuing.
  - No frame_done is generated for the aborted frame.
- Not defined: frame_start while frame_busy=1 is ignored; the current frame completes unchanged.

## Test plan
- FB_W=4, FB_H=2, x0=-8388608 (-2.0), y0=4194304 (1.0), step=2097152 (0.5); core model returns rgb=addr after 3 cycles → core_cx sequence -8388608, -6291456, -4194304, -2097152 repeats per row; core_cy=4194304 then 2097152; fb_addr 0..7 with data 0..7; exactly one frame_done.
- Same setup with fb_ready low for 5 cycles on addr 2 → fb_we, fb_addr=2, fb_wdata held for all 5 cycles; one write per address; no extra core_start issued during the stall.
- core_busy held high for 4 cycles after entering ISSUE → core_start stays low and is asserted on the first cycle core_busy=0.
- Spurious core_done while in ISSUE or WRITE → no state change and no extra write.
- rst asserted while the FSM is in WRITE on addr 5 → next cycle all outputs at reset values; a subsequent frame_start restarts from addr 0.
- frame_start mid-frame at addr 3: without the macro, addrs 4..7 complete normally and one frame_done is seen; with MANDEL_SCHED_ABORT_EN, no write to addr 4 occurs, addr 0 is issued with the new viewport, and one frame_done is seen in total.
